// File: rtl/ame_num_sched.sv
// Round-robin scheduler sharing one pipelined determinant unit (M*D - L*C) among
// NUM_REQ requesters. Define AME_NUM_SCHED_PRIO_EN to give requester 0 strict priority.
module ame_num_sched #(
  parameter int NUM_REQ        = 4,
  parameter int COMP_DATA_BITS = 64,
  parameter int COMP_LAT       = 2
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        enable_i,
  input  logic [NUM_REQ-1:0]                          req_valid_i,
  output logic [NUM_REQ-1:0]                          req_ready_o,
  input  logic [NUM_REQ-1:0][3:0][COMP_DATA_BITS-1:0] req_data_i,
  output logic                                        unit_init_o,
  output logic [3:0][COMP_DATA_BITS-1:0]              unit_data_o,
  input  logic [COMP_DATA_BITS-1:0]                   unit_data_i,
  output logic [NUM_REQ-1:0]                          rsp_valid_o,
  output logic [COMP_DATA_BITS-1:0]                   rsp_data_o,
  output logic                                        busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]                ptr_q;
  logic [IDX_W-1:0]                ptr_d;
  logic [IDX_W-1:0]                winner;
  logic                            grant;
  int                              scan_idx;
  logic [COMP_LAT:0]               tag_vld_q;
  logic [COMP_LAT:0][IDX_W-1:0]    tag_own_q;

  // Arbitration looks only at valids, pointer and enable, never at operand data.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path
    // through the block leaves a value unassigned and infers a latch.
    grant    = 1'b0;
    winner   = '0;
    scan_idx = 0;
`ifdef AME_NUM_SCHED_PRIO_EN
    if (req_valid_i[0]) begin
      grant = 1'b1;
    end else begin
      // Pointer lives in 1..NUM_REQ-1; a reset value of 0 is treated as 1.
      for (int i = 0; i < NUM_REQ - 1; i++) begin
        scan_idx = ((ptr_q == '0) ? 1 : int'(ptr_q)) + i;
        if (scan_idx >= NUM_REQ) scan_idx = scan_idx - (NUM_REQ - 1);
        if (!grant && req_valid_i[IDX_W'(scan_idx)]) begin
          grant  = 1'b1;
          winner = IDX_W'(scan_idx);
        end
      end
    end
`else
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = int'(ptr_q) + i;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!grant && req_valid_i[IDX_W'(scan_idx)]) begin
        grant  = 1'b1;
        winner = IDX_W'(scan_idx);
      end
    end
`endif
    if (!enable_i) grant = 1'b0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
`ifdef AME_NUM_SCHED_PRIO_EN
      if (winner != '0)
        ptr_d = (int'(winner) == NUM_REQ - 1) ? IDX_W'(1) : winner + 1'b1;
`else
      ptr_d = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
`endif
    end
  end

  assign req_ready_o = grant ? (NUM_REQ'(1) << winner) : '0;

  // The tag pipeline runs without stall; stage k lines up with the unit's k-th cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: owner fields are cleared with the valids only so that a reset leaves
      // every register at a known zero; correctness depends on the valid bits alone.
      ptr_q       <= '0;
      unit_data_o <= '0;
      tag_vld_q   <= '0;
      tag_own_q   <= '0;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's
      // old value, so the shift order inside the loop does not matter.
      ptr_q        <= ptr_d;
      unit_data_o  <= grant ? req_data_i[winner] : '0;
      tag_vld_q[0] <= grant;
      tag_own_q[0] <= winner;
      for (int k = 1; k <= COMP_LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_own_q[k] <= tag_own_q[k-1];
      end
      rsp_valid_o <= tag_vld_q[COMP_LAT] ? (NUM_REQ'(1) << tag_own_q[COMP_LAT]) : '0;
      if (tag_vld_q[COMP_LAT]) rsp_data_o <= unit_data_i;
    end
  end

  assign unit_init_o = tag_vld_q[0];
  assign busy_o      = (|tag_vld_q) | (|rsp_valid_o);

endmodule

// File: tb/tb_ame_num_sched.sv
// Directed bench for ame_num_sched with a behavioural two-stage determinant unit
// and a per-cycle scoreboard of unit, response and busy outputs.
module tb_ame_num_sched;

  localparam int NUM_REQ = 4;
  localparam int W       = 64;
  localparam int LAT     = 2;
  localparam int NCYC    = 512;

  logic                             clk_i = 1'b0;
  logic                             rst_i;
  logic                             enable_i;
  logic [NUM_REQ-1:0]               req_valid_i;
  logic [NUM_REQ-1:0]               req_ready_o;
  logic [NUM_REQ-1:0][3:0][W-1:0]   req_data_i;
  logic                             unit_init_o;
  logic [3:0][W-1:0]                unit_data_o;
  logic [W-1:0]                     unit_data_i;
  logic [NUM_REQ-1:0]               rsp_valid_o;
  logic [W-1:0]                     rsp_data_o;
  logic                             busy_o;

  logic [NUM_REQ-1:0][3:0][W-1:0]   ops;
  logic [W-1:0]                     pipe0, pipe1;

  typedef struct {
    logic               en;
    logic [NUM_REQ-1:0] vld;
    logic [NUM_REQ-1:0] exp_rdy;
  } vec_t;

  vec_t               vecs [10];
  logic               exp_init [NCYC];
  logic [3:0][W-1:0]  exp_udat [NCYC];
  logic [NUM_REQ-1:0] exp_rvld [NCYC];
  logic [W-1:0]       exp_rdat [NCYC];
  logic               exp_busy [NCYC];
  logic [W-1:0]       last_rdat;
  int                 total, bad, cyc, t2;

  always #5 clk_i = ~clk_i;

  ame_num_sched #(.NUM_REQ(NUM_REQ), .COMP_DATA_BITS(W), .COMP_LAT(LAT)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_data_i  (req_data_i),
    .unit_init_o (unit_init_o),
    .unit_data_o (unit_data_o),
    .unit_data_i (unit_data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .busy_o      (busy_o)
  );

  function automatic logic [W-1:0] det(input logic [3:0][W-1:0] op);
    return op[3] * op[2] - op[1] * op[0];
  endfunction

  // Shared determinant unit with LAT = 2 cycles of latency.
  always_ff @(posedge clk_i) begin
    pipe0 <= det(unit_data_o);
    pipe1 <= pipe0;
  end
  assign unit_data_i = pipe1;
  assign req_data_i  = ops;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < NCYC; i++) begin
      exp_init[i] = 1'b0;
      exp_udat[i] = '0;
      exp_rvld[i] = '0;
      exp_rdat[i] = '0;
      exp_busy[i] = 1'b0;
    end
  endtask

  task automatic record_hs(input int owner);
    exp_init[cyc+1] = 1'b1;
    exp_udat[cyc+1] = ops[owner];
    exp_rvld[cyc+LAT+2] = NUM_REQ'(1) << owner;
    exp_rdat[cyc+LAT+2] = det(ops[owner]);
    for (int i = cyc + 1; i <= cyc + LAT + 2; i++) exp_busy[i] = 1'b1;
  endtask

  task automatic next_cycle();
    #1;
    check("unit_init", unit_init_o, exp_init[cyc]);
    check("unit_data", unit_data_o, exp_udat[cyc]);
    check("rsp_valid", rsp_valid_o, exp_rvld[cyc]);
    if (exp_rvld[cyc] != '0) last_rdat = exp_rdat[cyc];
    check("rsp_data", rsp_data_o, last_rdat);
    check("busy", busy_o, exp_busy[cyc]);
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic apply(input logic en, input logic [NUM_REQ-1:0] vld,
                       input logic [NUM_REQ-1:0] exp_rdy, input string name);
    enable_i    = en;
    req_valid_i = vld;
    #1;
    check(name, req_ready_o, exp_rdy);
    for (int k = 0; k < NUM_REQ; k++) if (exp_rdy[k]) record_hs(k);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; cyc = 0; last_rdat = '0;
    rst_i = 1'b1; enable_i = 1'b0; req_valid_i = '0;
    for (int k = 0; k < NUM_REQ; k++)
      ops[k] = {W'(k + 3), W'(2 * k + 5), W'(k + 1), W'(7 - k)};
    repeat (3) @(posedge clk_i);
    #1;
    clear_from(0);
    rst_i = 1'b0;

    // Reset state, then requester 1 handshakes in cycle 10.
    check("rst_ready", req_ready_o, 4'b0000);
    while (cyc < 10) apply(1'b0, 4'b0000, 4'b0000, "idle_rdy");
    ops[1] = {64'd3, 64'd5, 64'd2, 64'd4};
    apply(1'b1, 4'b0010, 4'b0010, "tp1_grant");
    check("tp1_init", unit_init_o, 1'b1);
    check("tp1_udata", unit_data_o, {64'd3, 64'd5, 64'd2, 64'd4});
    repeat (3) apply(1'b1, 4'b0000, 4'b0000, "idle_rdy");
    check("tp1_rsp_vld", rsp_valid_o, 4'b0010);
    check("tp1_rsp_data", rsp_data_o, 64'd7);

    // Two's complement wrap to -1.
    ops[2] = {64'd0, 64'd0, 64'd1, 64'd1};
    apply(1'b1, 4'b0100, 4'b0100, "tp2_grant");
    repeat (3) apply(1'b1, 4'b0000, 4'b0000, "idle_rdy");
    check("tp2_rsp_vld", rsp_valid_o, 4'b0100);
    check("tp2_rsp_data", rsp_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (2) apply(1'b1, 4'b0000, 4'b0000, "idle_rdy");

    // Reset one cycle after a handshake: response discarded, pointer back to 0.
    apply(1'b1, 4'b0010, 4'b0010, "rst_grant");
    rst_i = 1'b1;
    req_valid_i = '0;
    next_cycle();
    clear_from(cyc);
    last_rdat = '0;
    rst_i = 1'b0;
    check("rst_rsp_vld", rsp_valid_o, 4'b0000);
    check("rst_init", unit_init_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_udata", unit_data_o, 256'd0);
    repeat (3) apply(1'b0, 4'b0000, 4'b0000, "idle_rdy");

`ifndef AME_NUM_SCHED_PRIO_EN
    // All four hold valid for 8 cycles: strict rotation from pointer 0.
    for (int i = 0; i < 8; i++) apply(1'b1, 4'b1111, 4'b0001 << (i % 4), "rr_grant");
    vecs[0] = '{1'b1, 4'b0000, 4'b0000};
    vecs[1] = '{1'b1, 4'b0100, 4'b0100};
    vecs[2] = '{1'b1, 4'b1111, 4'b1000};
    vecs[3] = '{1'b1, 4'b1111, 4'b0001};
    vecs[4] = '{1'b0, 4'b1111, 4'b0000};
    vecs[5] = '{1'b1, 4'b0001, 4'b0001};
    vecs[6] = '{1'b1, 4'b1010, 4'b0010};
    vecs[7] = '{1'b1, 4'b1010, 4'b1000};
    vecs[8] = '{1'b1, 4'b0110, 4'b0010};
    vecs[9] = '{1'b1, 4'b0011, 4'b0001};
`else
    // Pointer 0 after reset scans from requester 1.
    apply(1'b1, 4'b1110, 4'b0010, "rst_ptr0");
    vecs[0] = '{1'b1, 4'b1001, 4'b0001};
    vecs[1] = '{1'b1, 4'b1001, 4'b0001};
    vecs[2] = '{1'b1, 4'b1001, 4'b0001};
    vecs[3] = '{1'b1, 4'b1000, 4'b1000};
    vecs[4] = '{1'b1, 4'b1110, 4'b0010};
    vecs[5] = '{1'b1, 4'b1111, 4'b0001};
    vecs[6] = '{1'b1, 4'b1110, 4'b0100};
    vecs[7] = '{1'b0, 4'b1111, 4'b0000};
    vecs[8] = '{1'b1, 4'b0110, 4'b0010};
    vecs[9] = '{1'b1, 4'b0011, 4'b0001};
`endif
    for (int i = 0; i < 10; i++) apply(vecs[i].en, vecs[i].vld, vecs[i].exp_rdy, "vec_grant");
    repeat (6) apply(1'b1, 4'b0000, 4'b0000, "idle_rdy");

    // Enable drops after two handshakes; both responses still arrive.
    apply(1'b1, 4'b0010, 4'b0010, "en_grant0");
    apply(1'b1, 4'b0010, 4'b0010, "en_grant1");
    t2 = cyc - 1;
    while (cyc < t2 + 7) begin
      if (cyc == t2 + 4) begin
        check("en_last_rsp", rsp_valid_o, 4'b0010);
        check("en_busy_hi", busy_o, 1'b1);
      end
      if (cyc == t2 + 5) check("en_busy_lo", busy_o, 1'b0);
      apply(1'b0, 4'b1111, 4'b0000, "en_off_rdy");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
